// File: rtl/obsidian_dec_ex_mem.sv
// Three-stage LEGv8 slice: decode (register file), execute (ALU and branch
// resolution) and memory (data RAM). Write-back is driven from outside via
// WB_ID, so the pipeline has no stall, flush or forwarding paths.
module obsidian_dec_ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] IF_ID,
  input  logic [37:0] WB_ID,
  output logic [70:0] MEM_WB,
  output logic        branch_taken,
  output logic [31:0] branch_target
);

  typedef enum logic [2:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_LSL, ALU_LSR, ALU_MEM
  } alu_op_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        cbz;
    logic        uncond;
    alu_op_t     alu_op;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [5:0]  shamt;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        taken;
    logic [31:0] target;
  } ex_mem_t;

  logic [31:0] pc, instr;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  assign pc      = IF_ID[63:32];
  assign instr   = IF_ID[31:0];
  assign wb_we   = WB_ID[37];
  assign wb_rd   = WB_ID[36:32];
  assign wb_data = WB_ID[31:0];

  logic [31:0] regs [32];
  id_ex_t      dec, id_ex;
  logic        use_rt;
  logic [4:0]  rd2_addr;
  ex_mem_t     exe, ex_mem;
  logic [31:0] dmem [64] = '{default: 32'h0};
  logic [5:0]  mem_addr;
  logic [31:0] load_data;

  // Register file write port; X31 is never stored so it always reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we && wb_rd != 5'd31) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Decode: control bits, immediate selection and operand register addresses.
  always_comb begin
    dec        = '0;
    use_rt     = 1'b0;
    dec.pc     = pc;
    dec.shamt  = instr[15:10];
    dec.rd     = instr[4:0];
    if (instr[31:26] == 6'b000101) begin
      dec.uncond = 1'b1;
      dec.imm    = {{6{instr[25]}}, instr[25:0]};
    end else if (instr[31:24] == 8'hB4) begin
      dec.cbz = 1'b1;
      use_rt  = 1'b1;
      dec.imm = {{13{instr[23]}}, instr[23:5]};
    end else begin
      case (instr[31:21])
        11'h458: begin dec.reg_write = 1'b1; dec.alu_op = ALU_ADD; end
        11'h658: begin dec.reg_write = 1'b1; dec.alu_op = ALU_SUB; end
        11'h450: begin dec.reg_write = 1'b1; dec.alu_op = ALU_AND; end
        11'h550: begin dec.reg_write = 1'b1; dec.alu_op = ALU_ORR; end
        11'h69B: begin dec.reg_write = 1'b1; dec.alu_op = ALU_LSL; end
        11'h69A: begin dec.reg_write = 1'b1; dec.alu_op = ALU_LSR; end
        11'h7C2: begin
          dec.reg_write  = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.mem_read   = 1'b1;
          dec.alu_op     = ALU_MEM;
          dec.imm        = {{23{instr[20]}}, instr[20:12]};
        end
        11'h7C0: begin
          dec.mem_write = 1'b1;
          use_rt        = 1'b1;
          dec.alu_op    = ALU_MEM;
          dec.imm       = {{23{instr[20]}}, instr[20:12]};
        end
        default: ;
      endcase
    end
    rd2_addr = use_rt ? instr[4:0] : instr[20:16];
    // A same-cycle write to the addressed register is bypassed to the reader.
    if (instr[9:5] == 5'd31)                 dec.rd1 = '0;
    else if (wb_we && wb_rd == instr[9:5])   dec.rd1 = wb_data;
    else                                     dec.rd1 = regs[instr[9:5]];
    if (rd2_addr == 5'd31)                   dec.rd2 = '0;
    else if (wb_we && wb_rd == rd2_addr)     dec.rd2 = wb_data;
    else                                     dec.rd2 = regs[rd2_addr];
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_ex <= '0;
    else     id_ex <= dec;
  end

  // Execute: ALU operation, branch condition and PC-relative target.
  always_comb begin
    exe            = '0;
    exe.reg_write  = id_ex.reg_write;
    exe.mem_to_reg = id_ex.mem_to_reg;
    exe.mem_read   = id_ex.mem_read;
    exe.mem_write  = id_ex.mem_write;
    exe.store_data = id_ex.rd2;
    exe.rd         = id_ex.rd;
    case (id_ex.alu_op)
      ALU_ADD: exe.alu_result = id_ex.rd1 + id_ex.rd2;
      ALU_SUB: exe.alu_result = id_ex.rd1 - id_ex.rd2;
      ALU_AND: exe.alu_result = id_ex.rd1 & id_ex.rd2;
      ALU_ORR: exe.alu_result = id_ex.rd1 | id_ex.rd2;
      ALU_LSL: exe.alu_result = id_ex.rd1 << id_ex.shamt;
      ALU_LSR: exe.alu_result = id_ex.rd1 >> id_ex.shamt;
      ALU_MEM: exe.alu_result = id_ex.rd1 + id_ex.imm;
      default: exe.alu_result = '0;
    endcase
    exe.taken  = id_ex.uncond | (id_ex.cbz & (id_ex.rd2 == 32'h0));
    exe.target = id_ex.pc + (id_ex.imm << 2);
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_mem <= '0;
    else     ex_mem <= exe;
  end

  assign branch_taken  = ex_mem.taken;
  assign branch_target = ex_mem.target;

  assign mem_addr  = ex_mem.alu_result[7:2];
  assign load_data = ex_mem.mem_read ? dmem[mem_addr] : 32'h0;

  // Data memory store port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ex_mem.mem_write) dmem[mem_addr] <= ex_mem.store_data;
  end

  // MEM/WB output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) MEM_WB <= '0;
    else     MEM_WB <= {ex_mem.reg_write, ex_mem.mem_to_reg, load_data,
                        ex_mem.alu_result, ex_mem.rd};
  end

endmodule

// File: tb/tb_obsidian_dec_ex_mem.sv
// Directed self-checking bench for obsidian_dec_ex_mem.
module tb_obsidian_dec_ex_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] IF_ID = '0;
  logic [37:0] WB_ID = '0;
  logic [70:0] MEM_WB;
  logic        branch_taken;
  logic [31:0] branch_target;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog   [7];
  logic [31:0] exp_alu[7];
  logic [4:0]  exp_rd [7];

  obsidian_dec_ex_mem dut (
    .clk(clk), .rst(rst), .IF_ID(IF_ID), .WB_ID(WB_ID),
    .MEM_WB(MEM_WB), .branch_taken(branch_taken), .branch_target(branch_target)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [37:0] wb);
    IF_ID = {pc, instr};
    WB_ID = wb;
  endtask

  task automatic check_output(input string tag, input logic [70:0] observed,
                              input logic [70:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [70:0] wb_word(input logic rw, input logic m2r,
      input logic [31:0] rdata, input logic [31:0] alu, input logic [4:0] rd);
    return {rw, m2r, rdata, alu, rd};
  endfunction

  // Directed scenario sequence.
  initial begin
    tick();
    check_output("reset_mem_wb", MEM_WB, '0);
    check_output("reset_branch", {39'h0, branch_taken, branch_target}, '0);
    tick();
    rst = 1'b0;

    // Load from address 32 with X1=0 and zeroed memory.
    apply_stimulus(32'hFFFF_FFFF, {11'h7C2, 5'd2, 6'd1, 5'd1, 5'd4}, '0);
    tick();
    apply_stimulus('0, '0, '0);
    tick();
    check_output("load_no_branch", {70'h0, branch_taken}, '0);
    tick();
    check_output("load", MEM_WB, wb_word(1'b1, 1'b1, 32'h0, 32'd32, 5'd4));

    // ADD X4,X1,X1 while X1=100 is written in the same cycle (bypass).
    apply_stimulus('0, {11'h458, 5'd1, 6'd0, 5'd1, 5'd4}, {1'b1, 5'd1, 32'd100});
    tick();
    apply_stimulus('0, '0, {1'b1, 5'd2, 32'hDEAD_BEEF});
    tick();
    apply_stimulus('0, '0, '0);
    tick();
    check_output("add_bypass", MEM_WB, wb_word(1'b1, 1'b0, 32'h0, 32'd200, 5'd4));

    // STUR X2,[X31,#8] then LDUR X5,[X31,#8] back to back.
    apply_stimulus('0, {11'h7C0, 9'd8, 2'b00, 5'd31, 5'd2}, '0);
    tick();
    apply_stimulus('0, {11'h7C2, 9'd8, 2'b00, 5'd31, 5'd5}, '0);
    tick();
    apply_stimulus('0, '0, '0);
    tick();
    check_output("stur", MEM_WB, wb_word(1'b0, 1'b0, 32'h0, 32'd8, 5'd2));
    tick();
    check_output("ldur", MEM_WB, wb_word(1'b1, 1'b1, 32'hDEAD_BEEF, 32'd8, 5'd5));

    // Back-to-back ALU stream with X1=100, X2=0xDEADBEEF.
    prog[0] = {11'h658, 5'd1, 6'd0, 5'd2, 5'd6};  exp_alu[0] = 32'hDEAD_BE8B; exp_rd[0] = 5'd6;
    prog[1] = {11'h450, 5'd1, 6'd0, 5'd2, 5'd7};  exp_alu[1] = 32'h0000_0064; exp_rd[1] = 5'd7;
    prog[2] = {11'h550, 5'd1, 6'd0, 5'd2, 5'd8};  exp_alu[2] = 32'hDEAD_BEEF; exp_rd[2] = 5'd8;
    prog[3] = {11'h69B, 5'd0, 6'd4, 5'd1, 5'd9};  exp_alu[3] = 32'h0000_0640; exp_rd[3] = 5'd9;
    prog[4] = {11'h69A, 5'd0, 6'd8, 5'd2, 5'd10}; exp_alu[4] = 32'h00DE_ADBE; exp_rd[4] = 5'd10;
    prog[5] = {11'h658, 5'd2, 6'd0, 5'd1, 5'd11}; exp_alu[5] = 32'h2152_4175; exp_rd[5] = 5'd11;
    prog[6] = {11'h69A, 5'd0, 6'd31, 5'd2, 5'd12}; exp_alu[6] = 32'h0000_0001; exp_rd[6] = 5'd12;
    for (int s = 0; s < 9; s++) begin
      apply_stimulus('0, (s < 7) ? prog[s] : 32'h0, '0);
      tick();
      if (s >= 2)
        check_output($sformatf("alu%0d", s - 2), MEM_WB,
                     wb_word(1'b1, 1'b0, 32'h0, exp_alu[s-2], exp_rd[s-2]));
    end
    apply_stimulus('0, '0, '0);
    tick();

    // CBZ X31 (taken) then CBZ X1 (not taken), both at PC 0x100 with imm 4.
    apply_stimulus(32'h100, {8'hB4, 19'd4, 5'd31}, '0);
    tick();
    apply_stimulus(32'h100, {8'hB4, 19'd4, 5'd1}, '0);
    tick();
    check_output("cbz_taken", {38'h0, branch_taken, branch_target}, {38'h0, 1'b1, 32'h110});
    apply_stimulus('0, '0, '0);
    tick();
    check_output("cbz_not_taken", {38'h0, branch_taken, branch_target}, {38'h0, 1'b0, 32'h110});
    check_output("cbz_ctrl", {69'h0, MEM_WB[70:69]}, '0);

    // Unknown opcode behaves as a NOP.
    apply_stimulus('0, {11'h123, 5'd1, 6'd0, 5'd2, 5'd3}, '0);
    tick(); tick(); tick();
    check_output("nop_ctrl", {37'h0, MEM_WB[70:37]}, '0);

    // Write to X31 is ignored, even with a same-cycle read.
    apply_stimulus('0, {11'h458, 5'd31, 6'd0, 5'd31, 5'd4}, {1'b1, 5'd31, 32'd7});
    tick();
    apply_stimulus('0, {11'h458, 5'd31, 6'd0, 5'd31, 5'd4}, '0);
    tick();
    apply_stimulus('0, '0, '0);
    tick();
    check_output("xzr_bypass", MEM_WB, wb_word(1'b1, 1'b0, 32'h0, 32'h0, 5'd4));
    tick();
    check_output("xzr", MEM_WB, wb_word(1'b1, 1'b0, 32'h0, 32'h0, 5'd4));

    // Fill the pipe with ADD then a backward B, then reset mid-cycle.
    apply_stimulus('0, {11'h458, 5'd1, 6'd0, 5'd1, 5'd4}, '0);
    tick();
    apply_stimulus(32'h100, {6'b000101, 26'h3FF_FFFC}, '0);
    tick();
    apply_stimulus('0, {11'h458, 5'd1, 6'd0, 5'd1, 5'd4}, '0);
    tick();
    check_output("b_backward", {38'h0, branch_taken, branch_target}, {38'h0, 1'b1, 32'hF0});
    check_output("pre_reset_add", MEM_WB, wb_word(1'b1, 1'b0, 32'h0, 32'd200, 5'd4));
    #2;
    rst = 1'b1;
    #1;
    check_output("async_reset_mem_wb", MEM_WB, '0);
    check_output("async_reset_branch", {39'h0, branch_taken, branch_target}, '0);
    apply_stimulus('0, '0, '0);
    tick();
    rst = 1'b0;
    tick();
    check_output("flushed", MEM_WB, '0);

    // Registers were cleared by reset; data memory kept its contents.
    apply_stimulus('0, {11'h458, 5'd1, 6'd0, 5'd1, 5'd4}, '0);
    tick();
    apply_stimulus('0, {11'h7C2, 9'd8, 2'b00, 5'd31, 5'd5}, '0);
    tick();
    apply_stimulus('0, '0, '0);
    tick();
    check_output("regs_cleared", MEM_WB, wb_word(1'b1, 1'b0, 32'h0, 32'h0, 5'd4));
    tick();
    check_output("mem_kept", MEM_WB, wb_word(1'b1, 1'b1, 32'hDEAD_BEEF, 32'd8, 5'd5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
